// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: register file geometry and scoreboard counter width.
package riscv_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned CNT_W      = 2;

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down counter tracking outstanding writes to one architectural register.
module sb_counter
  import riscv_pkg::*;
#(
  parameter int unsigned MaxVal = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Simultaneous inc and dec cancel; clr wins over both.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec && cnt_q != CNT_W'(MaxVal)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register outstanding-write counters gating instruction issue.
// Optional SCOREBOARD_BYPASS_EN lets a source whose last pending write retires this cycle issue.
module reg_scoreboard
  import riscv_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_we,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] A1,
  input  logic [REG_ADDR_W-1:0] A2,
  input  logic                  WE3,
  input  logic [REG_ADDR_W-1:0] A3,
  input  logic                  flush,
  output logic                  stall,
  output logic                  issue_accept,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic [6:0]            inflight_total,
  output logic                  err
);

  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic             busy_a1, busy_a2, wr_full;
  logic             do_inc, do_dec, underflow;
  logic [6:0]       total_q, total_d;
  logic             err_q;

  assign cnt[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    sb_counter #(
      .MaxVal(MAX_INFLIGHT)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (do_inc && issue_rd == REG_ADDR_W'(i)),
      .dec (do_dec && A3 == REG_ADDR_W'(i)),
      .clr (flush),
      .cnt (cnt[i])
    );
  end

  always_comb begin
    busy_a1 = cnt[A1] != '0;
    busy_a2 = cnt[A2] != '0;
`ifdef SCOREBOARD_BYPASS_EN
    // Write-first register file: the retiring value is readable this cycle.
    if (WE3 && A3 == A1 && cnt[A1] == CNT_W'(1)) busy_a1 = 1'b0;
    if (WE3 && A3 == A2 && cnt[A2] == CNT_W'(1)) busy_a2 = 1'b0;
`endif
    wr_full      = issue_we && issue_rd != '0 && cnt[issue_rd] == CNT_W'(MAX_INFLIGHT);
    stall        = issue_valid && (busy_a1 || busy_a2 || wr_full);
    issue_accept = issue_valid && !stall;
    do_inc       = issue_accept && issue_we && issue_rd != '0;
    do_dec       = WE3 && A3 != '0 && cnt[A3] != '0;
    underflow    = WE3 && A3 != '0 && cnt[A3] == '0;
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < NUM_REGS; i++) busy_vec[i] = cnt[i] != '0;
  end

  always_comb begin
    total_d = total_q + {6'd0, do_inc} - {6'd0, do_dec};
    if (flush) total_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      total_q <= total_d;
      err_q   <= err_q | underflow;
    end
  end

  assign inflight_total = total_q;
  assign err            = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard against a counting reference model.
module tb_reg_scoreboard;

  localparam int MAX = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid, issue_we, WE3, flush;
  logic [4:0]  issue_rd, A1, A2, A3;
  logic        stall, issue_accept, err;
  logic [31:0] busy_vec;
  logic [6:0]  inflight_total;

  int m_cnt [32];
  bit m_err;
  int passed = 0;
  int total  = 0;

  reg_scoreboard #(
    .MAX_INFLIGHT(MAX)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_we       (issue_we),
    .issue_rd       (issue_rd),
    .A1             (A1),
    .A2             (A2),
    .WE3            (WE3),
    .A3             (A3),
    .flush          (flush),
    .stall          (stall),
    .issue_accept   (issue_accept),
    .busy_vec       (busy_vec),
    .inflight_total (inflight_total),
    .err            (err)
  );

  always #5 clk = ~clk;

  function automatic bit m_src_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef SCOREBOARD_BYPASS_EN
    if (m_cnt[a] == 1 && WE3 && A3 == a) return 1'b0;
`endif
    return m_cnt[a] != 0;
  endfunction

  function automatic bit m_stall();
    return issue_valid && (m_src_busy(A1) || m_src_busy(A2) ||
                           (issue_we && issue_rd != 0 && m_cnt[issue_rd] == MAX));
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] v = '0;
    for (int i = 1; i < 32; i++) v[i] = m_cnt[i] != 0;
    return v;
  endfunction

  function automatic int m_total();
    int s = 0;
    for (int i = 0; i < 32; i++) s += m_cnt[i];
    return s;
  endfunction

  function automatic bit stall_at_wb();
`ifdef SCOREBOARD_BYPASS_EN
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic drive(input logic v, we, input logic [4:0] rd, a1, a2,
                       input logic we3, input logic [4:0] a3, input logic fl);
    issue_valid = v; issue_we = we; issue_rd = rd; A1 = a1; A2 = a2;
    WE3 = we3; A3 = a3; flush = fl;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
  endtask

  // Advance one clock, updating the model from the inputs held this cycle.
  task automatic tick();
    bit acc, dec, und;
    acc = issue_valid && !m_stall();
    dec = WE3 && A3 != 0 && m_cnt[A3] > 0;
    und = WE3 && A3 != 0 && m_cnt[A3] == 0;
    @(posedge clk);
    if (und) m_err = 1'b1;
    if (flush) begin
      model_clear();
    end else begin
      if (dec) m_cnt[A3]--;
      if (acc && issue_we && issue_rd != 0) m_cnt[issue_rd]++;
    end
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    m_err = 1'b0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    total++; if (busy_vec !== 32'h0) $display("FAIL reset_busy: got %h want 0", busy_vec); else passed++;
    total++; if (inflight_total !== 7'd0) $display("FAIL reset_total: got %0d want 0", inflight_total); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    total++; if (stall !== 1'b0 || issue_accept !== 1'b0)
      $display("FAIL reset_idle: got stall=%b acc=%b want 0/0", stall, issue_accept); else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    m_err = 1'b0;
  endtask

  task automatic test_raw_stall();
    do_reset();
    drive(1, 1, 5, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (issue_accept !== 1'b1) $display("FAIL raw_issue: got acc=%b want 1", issue_accept); else passed++;
    tick();
    drive(1, 0, 0, 5, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (stall !== 1'b1) $display("FAIL raw_stall_c1: got %b want 1", stall); else passed++;
    tick();
    tick();
    drive(1, 0, 0, 5, 0, 1, 5, 0);
    @(negedge clk);
    total++; if (stall !== stall_at_wb()) $display("FAIL raw_stall_wb: got %b want %b", stall, stall_at_wb()); else passed++;
    tick();
    drive(1, 0, 0, 5, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (stall !== 1'b0 || issue_accept !== 1'b1)
      $display("FAIL raw_after_wb: got stall=%b acc=%b want 0/1", stall, issue_accept); else passed++;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 7, 0, 0, 0, 0, 0);
      @(negedge clk);
      total++; if (issue_accept !== 1'b1) $display("FAIL sat_accept%0d: got %b want 1", k, issue_accept); else passed++;
      tick();
    end
    drive(1, 1, 7, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (stall !== 1'b1) $display("FAIL sat_stall: got %b want 1", stall); else passed++;
    total++; if (busy_vec[7] !== 1'b1) $display("FAIL sat_busy7: got %b want 1", busy_vec[7]); else passed++;
    tick();
    @(negedge clk);
    total++; if (inflight_total !== 7'd3) $display("FAIL sat_total: got %0d want 3", inflight_total); else passed++;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive(1, 1, 9, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 9, 0, 0, 1, 9, 0);
    @(negedge clk);
    total++; if (issue_accept !== 1'b1) $display("FAIL same_accept: got %b want 1", issue_accept); else passed++;
    tick();
    drive(0, 0, 0, 0, 0, 1, 9, 0);
    @(negedge clk);
    total++; if (inflight_total !== 7'd1 || busy_vec !== 32'h200)
      $display("FAIL same_count: got total=%0d busy=%h want 1/00000200", inflight_total, busy_vec); else passed++;
    tick();
    @(negedge clk);
    total++; if (inflight_total !== 7'd0 || err !== 1'b0)
      $display("FAIL same_drain: got total=%0d err=%b want 0/0", inflight_total, err); else passed++;
  endtask

  task automatic test_underflow();
    do_reset();
    drive(1, 1, 3, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 12, 0);
    @(negedge clk);
    total++; if (err !== 1'b0) $display("FAIL uf_before: got %b want 0", err); else passed++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (err !== 1'b1) $display("FAIL uf_err: got %b want 1", err); else passed++;
    total++; if (busy_vec !== 32'h8 || inflight_total !== 7'd1)
      $display("FAIL uf_counts: got busy=%h total=%0d want 00000008/1", busy_vec, inflight_total); else passed++;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    total++; if (err !== 1'b1) $display("FAIL uf_sticky: got %b want 1", err); else passed++;
    do_reset();
    @(negedge clk);
    total++; if (err !== 1'b0) $display("FAIL uf_clr: got %b want 0", err); else passed++;
  endtask

  task automatic test_x0();
    do_reset();
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (issue_accept !== 1'b1 || stall !== 1'b0)
      $display("FAIL x0_issue: got acc=%b stall=%b want 1/0", issue_accept, stall); else passed++;
    tick();
    @(negedge clk);
    total++; if (busy_vec !== 32'h0 || inflight_total !== 7'd0)
      $display("FAIL x0_state: got busy=%h total=%0d want 0/0", busy_vec, inflight_total); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int r = 1; r <= 5; r++) begin
      drive(1, 1, 5'(r), 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 1, 6, 0, 0, 1, 1, 1);
    @(negedge clk);
    total++; if (inflight_total !== 7'd5 || busy_vec !== 32'h3e)
      $display("FAIL flush_pre: got total=%0d busy=%h want 5/0000003e", inflight_total, busy_vec); else passed++;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (inflight_total !== 7'd0 || busy_vec !== 32'h0)
      $display("FAIL flush_post: got total=%0d busy=%h want 0/0", inflight_total, busy_vec); else passed++;
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int r = 1; r <= 5; r++) begin
      drive(1, 1, 5'(r), 0, 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    total++; if (inflight_total !== 7'd0 || busy_vec !== 32'h0)
      $display("FAIL rst_mid: got total=%0d busy=%h want 0/0", inflight_total, busy_vec); else passed++;
    model_clear();
    m_err = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 0, 0, 3, 4, 0, 0, 0);
    @(negedge clk);
    total++; if (stall !== 1'b0) $display("FAIL rst_mid_stall: got %b want 0", stall); else passed++;
    tick();
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic fl, we3;
      fl  = $urandom_range(0, 39) == 0;
      we3 = !fl && ($urandom_range(0, 1) == 1);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), we3,
            5'($urandom_range(1, 7)), fl);
      @(negedge clk);
      total++;
      if (stall !== m_stall() || issue_accept !== (issue_valid && !m_stall()) ||
          busy_vec !== m_busy() || inflight_total !== 7'(m_total()) || err !== m_err) begin
        if (errs < 10)
          $display("FAIL rand_c%0d: got st=%b acc=%b busy=%h tot=%0d err=%b want st=%b busy=%h tot=%0d err=%b",
                   c, stall, issue_accept, busy_vec, inflight_total, err, m_stall(), m_busy(),
                   m_total(), m_err);
        errs++;
      end else begin
        passed++;
      end
      tick();
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    m_err = 1'b0;
    test_reset();
    test_raw_stall();
    test_saturation();
    test_same_cycle();
    test_underflow();
    test_x0();
    test_flush();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
